// File: rtl/updi_pkg.sv
// Shared types and widths for the UPDI PHY sequencer and its memory-port mux.
package updi_pkg;

  localparam int unsigned UPDI_DATA_W = 12;
  localparam int unsigned UPDI_ADDR_W = 7;

  typedef enum logic [2:0] {
    RST_PHY,
    IDLE,
    TX,
    GAP,
    RX,
    DONE
  } phy_sched_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CLIENT,
    GNT_PHY
  } mem_grant_t;

endpackage

// File: rtl/updi_mem_mux.sv
// Combinational grant mux for the single BUFF_MEM port (client vs PHY).
module updi_mem_mux
  import updi_pkg::*;
#(
  parameter int unsigned DATA_W = UPDI_DATA_W,
  parameter int unsigned ADDR_W = UPDI_ADDR_W
) (
  input  mem_grant_t        grant,
  input  logic              cli_csb,
  input  logic              cli_web,
  input  logic [ADDR_W-1:0] cli_addr,
  input  logic [DATA_W-1:0] cli_din,
  input  logic              phy_csb,
  input  logic              phy_web,
  input  logic [ADDR_W-1:0] phy_addr,
  input  logic [DATA_W-1:0] phy_din,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din
);

  always_comb begin
    mem_csb  = 1'b1;
    mem_web  = 1'b1;
    mem_addr = '0;
    mem_din  = '0;
    unique case (grant)
      GNT_CLIENT: begin
        mem_csb  = cli_csb;
        mem_web  = cli_web;
        mem_addr = cli_addr;
        mem_din  = cli_din;
      end
      GNT_PHY: begin
        mem_csb  = phy_csb;
        mem_web  = phy_web;
        mem_addr = phy_addr;
        mem_din  = phy_din;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/updi_phy_sched.sv
// UPDI PHY sequencer: loads TX frames, drives PHY rst/ten/ren, arbitrates BUFF_MEM.
// Optional RX watchdog: define UPDI_PHY_SCHED_TIMEOUT_EN.
module updi_phy_sched
  import updi_pkg::*;
#(
  parameter int unsigned DATA_W      = UPDI_DATA_W,
  parameter int unsigned ADDR_W      = UPDI_ADDR_W,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start,
  input  logic              i_rx_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [ADDR_W:0]   o_wr_count,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_phy_rst,
  output logic              o_ten,
  output logic              o_ren,
  input  logic              i_tend,
  input  logic              i_rend,
  input  logic              i_phy_csb0,
  input  logic              i_phy_web0,
  input  logic [ADDR_W-1:0] i_phy_addr0,
  input  logic [DATA_W-1:0] i_phy_din0,
  output logic              o_csb0,
  output logic              o_web0,
  output logic [ADDR_W-1:0] o_addr0,
  output logic [DATA_W-1:0] o_din0,
  input  logic [DATA_W-1:0] i_dout0
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  phy_sched_state_t state, state_nxt;
  mem_grant_t       grant;

  logic [RST_W-1:0]  rst_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ADDR_W:0]   wr_ptr;
  logic              rx_lat;
  logic              rd_valid_q;
  logic              wr_fire;
  logic              rd_issue;
  logic              rst_last;
  logic              gap_last;
  logic              tmo_hit;
  logic              cli_csb;
  logic              cli_web;
  logic [ADDR_W-1:0] cli_addr;
  logic [DATA_W-1:0] cli_din;

  assign rst_last = (rst_cnt == RST_W'(RST_CYCLES - 1));
  assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

`ifdef UPDI_PHY_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)          tmo_cnt <= '0;
    else if (state != RX) tmo_cnt <= '0;
    else                  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // A coincident i_rend still wins over the watchdog.
  assign tmo_hit = (state == RX) && !i_rend && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  // Watchdog not built; the parameter stays for interface compatibility.
  assign tmo_hit = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= RST_PHY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RST_PHY: if (rst_last) state_nxt = IDLE;
      IDLE:    if (i_start && (wr_ptr != '0)) state_nxt = TX;
      TX:      if (i_tend) state_nxt = rx_lat ? GAP : DONE;
      GAP:     if (gap_last) state_nxt = RX;
      RX: begin
        if (tmo_hit)     state_nxt = RST_PHY;
        else if (i_rend) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = RST_PHY;
    endcase
  end

  always_comb begin
    o_phy_rst  = (state == RST_PHY);
    o_ten      = (state == TX);
    o_ren      = (state == RX) && !tmo_hit;
    o_busy     = (state != IDLE);
    o_done     = (state == DONE) || tmo_hit;
    o_timeout  = tmo_hit;
    o_wr_ready = (state == IDLE) && (wr_ptr < FULL);
    unique case (state)
      IDLE:    grant = GNT_CLIENT;
      TX, RX:  grant = GNT_PHY;
      default: grant = GNT_NONE;
    endcase
  end

  // Client port: a write in the same cycle pre-empts a read, which simply retries.
  always_comb begin
    wr_fire  = i_wr_valid && o_wr_ready;
    rd_issue = (state == IDLE) && i_rd_req && !wr_fire;
    cli_csb  = !(wr_fire || rd_issue);
    cli_web  = !wr_fire;
    cli_addr = wr_fire ? wr_ptr[ADDR_W-1:0] : i_rd_addr;
    cli_din  = wr_fire ? i_wr_data : '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rst_cnt    <= '0;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rx_lat     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rst_cnt    <= (state == RST_PHY) ? rst_cnt + RST_W'(1) : '0;
      gap_cnt    <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      rd_valid_q <= rd_issue;
      if (state == IDLE && i_start) rx_lat <= i_rx_en;
      if (state == DONE || state == RST_PHY) wr_ptr <= '0;
      else if (wr_fire)                      wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
    end
  end

  assign o_wr_count = wr_ptr;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_valid_q ? i_dout0 : '0;

  updi_mem_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem_mux (
    .grant    (grant),
    .cli_csb  (cli_csb),
    .cli_web  (cli_web),
    .cli_addr (cli_addr),
    .cli_din  (cli_din),
    .phy_csb  (i_phy_csb0),
    .phy_web  (i_phy_web0),
    .phy_addr (i_phy_addr0),
    .phy_din  (i_phy_din0),
    .mem_csb  (o_csb0),
    .mem_web  (o_web0),
    .mem_addr (o_addr0),
    .mem_din  (o_din0)
  );

endmodule

// File: tb/tb_updi_phy_sched.sv
// Randomized bench for updi_phy_sched with an SRAM model and a transaction-level reference.
`timescale 1ns/1ps
module tb_updi_phy_sched;

  localparam int DW    = 12;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int RSTC  = 4;
  localparam int GAPC  = 2;
`ifdef UPDI_PHY_SCHED_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0, rx_en = 1'b0;
  logic          busy, done, timeout;
  logic [AW:0]   wr_count;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          phy_rst, ten, ren;
  logic          tend = 1'b0, rend = 1'b0;
  logic          phy_csb = 1'b1, phy_web = 1'b1;
  logic [AW-1:0] phy_addr = '0;
  logic [DW-1:0] phy_din = '0;
  logic          csb0, web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  updi_phy_sched #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .RST_CYCLES(RSTC), .GAP_CYCLES(GAPC), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .i_start(start), .i_rx_en(rx_en),
    .o_busy(busy), .o_done(done), .o_timeout(timeout), .o_wr_count(wr_count),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_phy_rst(phy_rst), .o_ten(ten), .o_ren(ren), .i_tend(tend), .i_rend(rend),
    .i_phy_csb0(phy_csb), .i_phy_web0(phy_web), .i_phy_addr0(phy_addr), .i_phy_din0(phy_din),
    .o_csb0(csb0), .o_web0(web0), .o_addr0(addr0), .o_din0(din0), .i_dout0(dout)
  );

  // Single-port synchronous SRAM standing in for BUFF_MEM.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) sram[addr0] <= din0;
      else       dout <= sram[addr0];
    end
  end

  // Reference: expected memory image, load count and highest address known to be written.
  logic [DW-1:0] ref_mem [DEPTH];
  int ref_count = 0;
  int hi_water  = 0;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phy_reset();
    int n = 0;
    do begin tick(); n++; end while (phy_rst && n < 100);
    chk("rst_len", n, RSTC);
    chk("idle_busy", busy, 0);
    chk("idle_cnt", wr_count, 0);
    ref_count = 0;
  endtask

  task automatic client_write(input logic [DW-1:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("wr_stall", 0, 1);
    tick();
    wr_valid = 1'b0;
    ref_mem[ref_count] = d;
    ref_count++;
    if (ref_count > hi_water) hi_water = ref_count;
    chk("wr_count", wr_count, ref_count);
  endtask

  task automatic client_read(input int a);
    int n = 0;
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    do begin tick(); n++; end while (!rd_valid && n < 20);
    rd_req = 1'b0;
    chk("rd_lat", n, 1);
    chk("rd_data", rd_data, ref_mem[a]);
  endtask

  task automatic write_read(input logic [DW-1:0] d, input int a);
    int n = 1;
    wr_valid = 1'b1;
    wr_data  = d;
    rd_req   = 1'b1;
    rd_addr  = AW'(a);
    @(negedge clk);
    chk("wr_rdy_c", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    ref_mem[ref_count] = d;
    ref_count++;
    if (ref_count > hi_water) hi_water = ref_count;
    chk("rd_yield", rd_valid, 0);
    while (!rd_valid && n < 20) begin tick(); n++; end
    rd_req = 1'b0;
    chk("rd_lat_c", n, 2);
    chk("rd_data_c", rd_data, ref_mem[a]);
  endtask

  task automatic run_txn(input bit rx, input int tx_len, input int rx_len,
                         input int waddr, input logic [DW-1:0] wdata);
    int n;
    int a;
    start = 1'b1;
    rx_en = rx;
    tick();
    start = 1'b0;
    rx_en = 1'b0;
    chk("ten_on", ten, 1);
    chk("tx_busy", busy, 1);
    chk("tx_wr_rdy", wr_ready, 0);
    n = 0;
    while (ten && n < 200) begin
      n++;
      a = $urandom_range(0, hi_water - 1);
      phy_csb  = 1'b0;
      phy_web  = 1'b1;
      phy_addr = AW'(a);
      if (n == tx_len) begin tend = 1'b1; rend = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      chk("phy_csb", csb0, 0);
      chk("phy_addr", addr0, a);
      tick();
      tend = 1'b0;
      rend = 1'b0;
      phy_csb = 1'b1;
      chk("phy_rd", dout, ref_mem[a]);
    end
    chk("ten_len", n, tx_len);
    if (rx) begin
      n = 0;
      phy_csb = 1'b0;
      phy_web = 1'b0;
      while (!ren && n < 20) begin
        @(negedge clk);
        chk("gap_csb", csb0, 1);
        chk("gap_done", done, 0);
        n++;
        tick();
      end
      phy_csb = 1'b1;
      phy_web = 1'b1;
      chk("gap_len", n, GAPC);
      n = 0;
      while (ren && n < TMO + 50) begin
        n++;
        if (n == 1) begin
          phy_csb = 1'b0; phy_web = 1'b0; phy_addr = AW'(waddr); phy_din = wdata;
          @(negedge clk);
          chk("rx_web", web0, 0);
          chk("rx_din", din0, wdata);
        end
        if (n == rx_len) rend = 1'b1;
        tick();
        if (n == 1) ref_mem[waddr] = wdata;
        phy_csb = 1'b1;
        phy_web = 1'b1;
        rend = 1'b0;
      end
      chk("ren_len", n, rx_len);
    end
    chk("done_on", done, 1);
    chk("done_tmo", timeout, 0);
    tick();
    chk("done_off", done, 0);
    chk("end_busy", busy, 0);
    chk("end_cnt", wr_count, 0);
    ref_count = 0;
  endtask

  initial begin
    int nw;
    int a;
    @(negedge clk);
    @(negedge clk);
    chk("rst_phy", phy_rst, 1);
    chk("rst_csb", csb0, 1);
    chk("rst_web", web0, 1);
    chk("rst_ten", ten, 0);
    chk("rst_ren", ren, 0);
    chk("rst_done", done, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_cnt", wr_count, 0);
    rst_n = 1'b1;
    wait_phy_reset();

    client_write(12'h0A5);
    client_write(12'h155);
    client_write(12'h2AA);
    client_read(1);
    run_txn(1'b0, 20, 0, 0, '0);
    client_write(12'h777);
    run_txn(1'b1, 5, 7, 5, 12'h3C3);
    client_read(5);

    // Start with an empty buffer and stray PHY strobes in IDLE must be ignored.
    start = 1'b1; rx_en = 1'b1; tend = 1'b1; rend = 1'b1;
    tick();
    start = 1'b0; rx_en = 1'b0; tend = 1'b0; rend = 1'b0;
    chk("start_empty", busy, 0);
    chk("start_empty_ten", ten, 0);

    for (int it = 0; it < 12; it++) begin
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        if (hi_water > 0 && $urandom_range(0, 3) == 0)
          write_read(DW'($urandom), $urandom_range(0, hi_water - 1));
        else
          client_write(DW'($urandom));
      end
      repeat (2) client_read($urandom_range(0, hi_water - 1));
      tend = 1'($urandom_range(0, 1));
      rend = 1'($urandom_range(0, 1));
      tick();
      tend = 1'b0; rend = 1'b0;
      chk("idle_strobe", busy, 0);
      run_txn(1'($urandom_range(0, 1)), $urandom_range(1, 10), $urandom_range(1, 10),
              $urandom_range(0, hi_water - 1), DW'($urandom));
    end

    while (ref_count < DEPTH) client_write(DW'($urandom));
    @(negedge clk);
    chk("full_rdy", wr_ready, 0);
    chk("full_cnt", wr_count, DEPTH);
    wr_valid = 1'b1;
    wr_data  = 12'hFFF;
    repeat (3) tick();
    wr_valid = 1'b0;
    chk("full_hold", wr_count, DEPTH);
    client_read($urandom_range(0, DEPTH - 1));
    run_txn(1'b0, 3, 0, 0, '0);

    client_write(12'h123);
    client_write(12'h456);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_phy", phy_rst, 1);
    chk("mid_ten", ten, 0);
    chk("mid_cnt", wr_count, 0);
    chk("mid_csb", csb0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_phy_reset();

`ifdef UPDI_PHY_SCHED_TIMEOUT_EN
    begin
      int n;
      client_write(12'h0F0);
      start = 1'b1; rx_en = 1'b1;
      tick();
      start = 1'b0; rx_en = 1'b0;
      n = 0;
      while (ten && n < 50) begin
        n++;
        if (n == 2) tend = 1'b1;
        tick();
        tend = 1'b0;
      end
      n = 0;
      while (!ren && n < 20) begin tick(); n++; end
      n = 0;
      while (ren && n < TMO + 20) begin tick(); n++; end
      chk("tmo_len", n, TMO - 1);
      chk("tmo_done", done, 1);
      chk("tmo_flag", timeout, 1);
      tick();
      chk("tmo_rst", phy_rst, 1);
      chk("tmo_done_off", done, 0);
      n = 1;
      while (phy_rst && n < 100) begin tick(); n++; end
      chk("tmo_rst_len", n, RSTC);
      chk("tmo_idle", busy, 0);
      chk("tmo_cnt", wr_count, 0);
      ref_count = 0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
